// File: rtl/free_list_if.sv
// Rename/retire-side bundle of the physical-register free list: dispatch requests,
// retire returns, grants and debug visibility.
interface free_list_if #(
    parameter int unsigned PR  = 6,
    parameter int unsigned FLW = 5
);
    logic [2:0]         dispatch_req;
    logic [2:0]         retire_valid;
    logic [2:0][PR-1:0] retire_told;
    logic [2:0][PR-1:0] alloc_pr;
    logic [2:0]         struct_stall;
    logic [FLW:0]       free_count;
    logic [FLW-1:0]     head_display;
    logic [FLW-1:0]     tail_display;

    modport master (
        output dispatch_req, retire_valid, retire_told,
        input  alloc_pr, struct_stall, free_count, head_display, tail_display
    );

    modport slave (
        input  dispatch_req, retire_valid, retire_told,
        output alloc_pr, struct_stall, free_count, head_display, tail_display
    );
endinterface

// File: rtl/free_list.sv
// Circular physical-register free list: 3-wide allocate at head for dispatch,
// 3-wide compacted return of stale mappings at tail from ROB retire.
module free_list #(
    parameter int unsigned PR        = 6,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned FL_DEPTH  = 32,
    parameter int unsigned FLW       = 5
) (
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave fl
);

    localparam int unsigned CW = FLW + 1;

    logic [PR-1:0]  list_q [FL_DEPTH];
    logic [FLW-1:0] head_q, head_d;
    logic [FLW-1:0] tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic [2:0]     stall_c;
    logic [2:0]     grant_c;
    logic [1:0]     n_alloc_c;
    logic [2:0]     qual_c;
    logic [1:0]     pos_c [3];
    logic [1:0]     n_free_raw_c;
    logic [1:0]     n_free_c;
    logic [CW-1:0]  room_c;
    logic [2:0]     wr_en_c;
    logic [FLW-1:0] wr_idx_c [3];

    // Stall is a pure function of the registered count, so it never depends on this cycle's frees.
    always_comb begin
        stall_c = 3'b111;
        if (count_q >= CW'(3))      stall_c = 3'b000;
        else if (count_q == CW'(2)) stall_c = 3'b100;
        else if (count_q == CW'(1)) stall_c = 3'b110;
    end

    always_comb begin
        grant_c   = fl.dispatch_req & ~stall_c;
        n_alloc_c = 2'(grant_c[0]) + 2'(grant_c[1]) + 2'(grant_c[2]);
    end

    // PR 0 is hard-wired and must never re-enter the list.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            qual_c[i] = fl.retire_valid[i] && (fl.retire_told[i] != '0);
        end
        pos_c[0]     = 2'd0;
        pos_c[1]     = 2'(qual_c[0]);
        pos_c[2]     = pos_c[1] + 2'(qual_c[1]);
        n_free_raw_c = pos_c[2] + 2'(qual_c[2]);
    end

    // Room left after this cycle's allocation; frees beyond it are dropped.
    always_comb begin
        room_c   = CW'(FL_DEPTH) - count_q + CW'(n_alloc_c);
        n_free_c = n_free_raw_c;
        if (CW'(n_free_raw_c) > room_c) n_free_c = room_c[1:0];
    end

    // Compact qualifying ways in way order onto consecutive slots starting at tail.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            wr_en_c[i]  = qual_c[i] && (pos_c[i] < n_free_c);
            wr_idx_c[i] = tail_q + FLW'(pos_c[i]);
        end
    end

    always_comb begin
        head_d  = head_q + FLW'(n_alloc_c);
        tail_d  = tail_q + FLW'(n_free_c);
        count_d = count_q - CW'(n_alloc_c) + CW'(n_free_c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(FL_DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slots above the architectural registers start out free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                list_q[i] <= PR'(ARCH_REGS + i);
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (wr_en_c[i]) list_q[wr_idx_c[i]] <= fl.retire_told[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            fl.alloc_pr[i] = list_q[head_q + FLW'(i)];
        end
        fl.struct_stall = stall_c;
        fl.free_count   = count_q;
        fl.head_display = head_q;
        fl.tail_display = tail_q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (fl.dispatch_req inside {3'b000, 3'b001, 3'b011, 3'b111})
                else $error("free_list: non-prefix dispatch_req %b", fl.dispatch_req);
            assert (CW'(n_free_raw_c) <= room_c)
                else $error("free_list: overflow, %0d frees with room %0d", n_free_raw_c, room_c);
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation, stall thresholds, compacted frees,
// wrap-around and asynchronous reset.
module tb_free_list;

    localparam int unsigned PR  = 6;
    localparam int unsigned FLW = 5;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    free_list_if #(.PR(PR), .FLW(FLW)) fl ();

    free_list #(.PR(PR), .ARCH_REGS(32), .FL_DEPTH(32), .FLW(FLW)) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3*PR-1:0] pr3(input int unsigned w2, input int unsigned w1,
                                            input int unsigned w0);
        return {PR'(w2), PR'(w1), PR'(w0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] rv,
                         input int unsigned t0, input int unsigned t1, input int unsigned t2);
        fl.dispatch_req   = req;
        fl.retire_valid   = rv;
        fl.retire_told[0] = PR'(t0);
        fl.retire_told[1] = PR'(t1);
        fl.retire_told[2] = PR'(t2);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(fl.free_count), 32);
        chk({tag, "_stall"}, 32'(fl.struct_stall), 0);
        chk({tag, "_alloc"}, 32'(fl.alloc_pr), 32'(pr3(34, 33, 32)));
        chk({tag, "_head"},  32'(fl.head_display), 0);
        chk({tag, "_tail"},  32'(fl.tail_display), 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_state("rst");

        // Two full-width allocations from a fresh list.
        drive(3'b111, 3'b000, 0, 0, 0);
        #1 chk("alloc1_pr", 32'(fl.alloc_pr), 32'(pr3(34, 33, 32)));
        tick();
        chk("alloc2_pr", 32'(fl.alloc_pr), 32'(pr3(37, 36, 35)));
        tick();
        chk("alloc2_count", 32'(fl.free_count), 26);
        chk("alloc2_head",  32'(fl.head_display), 6);

        // Drain down to two entries: head 30, list[30..31] = 62, 63.
        repeat (8) tick();
        chk("drain_count", 32'(fl.free_count), 2);
        chk("drain_head",  32'(fl.head_display), 30);
        chk("stall_at2",   32'(fl.struct_stall), 32'b100);
        chk("alloc_at2_w0", 32'(fl.alloc_pr[0]), 62);
        chk("alloc_at2_w1", 32'(fl.alloc_pr[1]), 63);
        tick();
        chk("partial_count", 32'(fl.free_count), 0);
        chk("partial_head",  32'(fl.head_display), 0);
        chk("stall_at0",     32'(fl.struct_stall), 32'b111);
        tick();
        chk("empty_count", 32'(fl.free_count), 0);
        chk("empty_head",  32'(fl.head_display), 0);

        // Free into an empty list; no same-cycle bypass.
        drive(3'b000, 3'b111, 5, 6, 2);
        #1 chk("free_empty_stall_same", 32'(fl.struct_stall), 32'b111);
        tick();
        chk("free_empty_count", 32'(fl.free_count), 3);
        chk("free_empty_stall", 32'(fl.struct_stall), 0);
        chk("free_empty_alloc", 32'(fl.alloc_pr), 32'(pr3(2, 6, 5)));
        chk("free_empty_tail",  32'(fl.tail_display), 3);

        // PR 0 is filtered; only 7 enters at slot 3.
        drive(3'b000, 3'b111, 0, 7, 0);
        tick();
        chk("x0_count", 32'(fl.free_count), 4);
        chk("x0_tail",  32'(fl.tail_display), 4);

        drive(3'b000, 3'b111, 8, 9, 10);
        tick();
        drive(3'b000, 3'b111, 11, 12, 13);
        tick();
        chk("fill_count", 32'(fl.free_count), 10);
        chk("fill_tail",  32'(fl.tail_display), 10);

        // Simultaneous allocate and free keeps count steady.
        drive(3'b111, 3'b111, 40, 41, 42);
        #1 chk("simul_alloc_pr", 32'(fl.alloc_pr), 32'(pr3(2, 6, 5)));
        tick();
        chk("simul_count", 32'(fl.free_count), 10);
        chk("simul_tail",  32'(fl.tail_display), 13);
        chk("simul_head",  32'(fl.head_display), 3);
        chk("simul_next_pr", 32'(fl.alloc_pr), 32'(pr3(9, 8, 7)));

        drive(3'b111, 3'b000, 0, 0, 0);
        tick();
        tick();
        drive(3'b001, 3'b000, 0, 0, 0);
        tick();
        chk("reach40_head",  32'(fl.head_display), 10);
        chk("reach40_count", 32'(fl.free_count), 3);
        chk("reach40_pr",    32'(fl.alloc_pr), 32'(pr3(42, 41, 40)));

        // Eight balanced cycles carry both pointers past slot 31.
        drive(3'b111, 3'b111, 50, 51, 52);
        repeat (8) tick();
        chk("wrap_head",  32'(fl.head_display), 2);
        chk("wrap_tail",  32'(fl.tail_display), 5);
        chk("wrap_count", 32'(fl.free_count), 3);
        chk("wrap_pr",    32'(fl.alloc_pr), 32'(pr3(52, 51, 50)));

        drive(3'b011, 3'b000, 0, 0, 0);
        tick();
        chk("one_left_count", 32'(fl.free_count), 1);
        chk("one_left_stall", 32'(fl.struct_stall), 32'b110);
        chk("one_left_pr0",   32'(fl.alloc_pr[0]), 52);

        // Reset asserted between edges takes effect at once.
        drive(3'b111, 3'b000, 0, 0, 0);
        #3 reset = 1'b1;
        #1 chk_reset_state("midrst");
        #2 reset = 1'b0;
        drive(3'b000, 3'b000, 0, 0, 0);
        tick();
        chk_reset_state("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
